pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_skid_reg_sat_counter.sv | 24 ++
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe skid register: state encodings and default sizes.
// The stall counter is included only when PIPE_SKID_STALL_CNT_EN is defined.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter; it holds at all-ones instead of wrapping.
// It is used by pipe_skid_reg only when PIPE_SKID_STALL_CNT_EN is defined.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register. in_ready is decoded only from registered state.
// Define PIPE_SKID_STALL_CNT_EN to add the saturating back-pressure counter on stall_cnt.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int CNT_W = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 1024 || CNT_W < 4 || CNT_W > 32) begin : g_bad_param
        $error("pipe_skid_reg: WIDTH must be 1..1024 and CNT_W must be 4..32");
    end

    skid_state_e      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_pop;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // The handshake flags are kept in the same registers as the state, so both always agree.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // NOTE: the payload registers are cleared too, because out_data must read 0 whenever nothing is held.
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ONE;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    case ({w_accept, w_pop})
                        2'b10: begin
                            r_state    <= FULL;
                            r_skid     <= in_data;
                            r_in_ready <= 1'b0;
                        end
                        2'b11: r_main <= in_data;
                        2'b01: begin
                            r_state     <= EMPTY;
                            r_main      <= '0;
                            r_out_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (w_pop) begin
                        r_state    <= ONE;
                        r_main     <= r_skid;
                        r_skid     <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main      <= '0;
                    r_skid      <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic w_stall;

    // A stall is a held head entry that downstream declines; flush does not clear the count.
    assign w_stall = r_out_valid && !out_ready;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_stall),
        .count(stall_cnt)
    );
`endif

endmodule
